cb_executor: RTL and testbench

- Sequencer for all 256 CB-prefixed instructions: rotate/shift/swap, BIT, RES and SET.
- Takes a CB opcode from the core decoder, fetches the operand from a register or from (HL), drives the shared ALU, then writes the result and flags back.
- Sits between the instruction decoder, register file, memory bus master and ALU.
- The ALU stays external; this block only drives its op, operands and flag input, and consumes its outputs.

---
 rtl/cb_executor_pkg.sv | 28 ++
 rtl/cb_executor_if.sv | 11 +
 rtl/cb_executor_decode.sv | 19 +
 rtl/cb_executor.sv | 111 +++++++++++
 tb/tb_cb_executor.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cb_executor_pkg.sv
// cb_executor_pkg: shared encodings for the CB-prefix sequencer and its decoder
package cb_executor_pkg;
  typedef enum logic [2:0] {IDLE, MEM_RD, EXEC, MEM_WR, DONE} stateT;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;
  localparam logic [1:0] GRP_SHIFT = 2'b00;
  localparam logic [1:0] GRP_BIT = 2'b01;
  localparam logic [1:0] GRP_RES = 2'b10;
  localparam logic [1:0] GRP_SET = 2'b11;
  localparam logic [2:0] REG_HL_IND = 3'd6;
  // Rotate/shift ops are contiguous so the CB sub field indexes them directly.
  localparam logic [7:0] ALU_RLC = 8'h10;
  localparam logic [7:0] ALU_RRC = 8'h11;
  localparam logic [7:0] ALU_RL = 8'h12;
  localparam logic [7:0] ALU_RR = 8'h13;
  localparam logic [7:0] ALU_SLA = 8'h14;
  localparam logic [7:0] ALU_SRA = 8'h15;
  localparam logic [7:0] ALU_SWAP = 8'h16;
  localparam logic [7:0] ALU_SRL = 8'h17;
  localparam logic [7:0] ALU_BIT = 8'h20;
  localparam logic [7:0] ALU_RES = 8'h30;
  localparam logic [7:0] ALU_SET = 8'h40;
  function automatic logic isMemOperand(input logic [7:0] op);
    return op[2:0] == REG_HL_IND;
  endfunction
endpackage

// File: rtl/cb_executor_if.sv
// cb_executor_if: memory bus between the CB sequencer (master) and the bus unit
interface cb_executor_if;
  logic req;
  logic we;
  logic [15:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic ack;
  modport master(output req, we, addr, wdata, input rdata, ack);
  modport slave(input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/cb_executor_decode.sv
// cb_decode: combinational CB opcode decode into ALU op and writeback controls
module cb_decode
  import cb_executor_pkg::*;
(
  input  logic [7:0] op,
  output logic [7:0] aluOp,
  output logic       isMem,
  output logic       isBit,
  output logic       writesReg,
  output logic       writesFlags
);
  logic [3:0] bitGroupOp;
  assign bitGroupOp = op[7:6] == GRP_BIT ? ALU_BIT[7:4] : op[7:6] == GRP_RES ? ALU_RES[7:4] : ALU_SET[7:4];
  assign aluOp = op[7:6] == GRP_SHIFT ? ALU_RLC + 8'(op[5:3]) : {bitGroupOp, 1'b0, op[5:3]};
  assign isMem = isMemOperand(op);
  assign isBit = op[7:6] == GRP_BIT;
  assign writesReg = !isBit && !isMem;
  assign writesFlags = op[7:6] == GRP_SHIFT || isBit;
endmodule

// File: rtl/cb_executor.sv
// cb_executor: sequences one CB-prefixed instruction through operand fetch, ALU and writeback
module cb_executor
  import cb_executor_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        cb_opcode,
  output logic              busy,
  output logic              done,
  input  logic [15:0]       hl,
  input  logic [3:0]        flags_in,
  output logic [3:0]        flags_out,
  output logic              flags_we,
  output logic [2:0]        rf_rsel,
  input  logic [7:0]        rf_rdata,
  output logic              rf_we,
  output logic [2:0]        rf_wsel,
  output logic [7:0]        rf_wdata,
  cb_executor_if.master     mem,
  output logic [7:0]        alu_op,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic [3:0]        alu_fin,
  input  logic [15:0]       alu_o,
  input  logic [3:0]        alu_fout
);
  stateT state, nextState;
  logic [7:0] opReg, memData, wrData, aluOp, operand;
  logic [3:0] newFlags;
  logic isMem, isBit, writesReg, writesFlags;
  cb_decode u_decode (
    .op(opReg),
    .aluOp(aluOp),
    .isMem(isMem),
    .isBit(isBit),
    .writesReg(writesReg),
    .writesFlags(writesFlags)
  );
  assign operand = isMem ? memData : rf_rdata;
  // Rotate Z is taken from the byte result because the ALU reports it on the 16-bit value.
  assign newFlags = isBit ? {alu_fout[FLAG_Z], alu_fout[FLAG_N], alu_fout[FLAG_H], flags_in[FLAG_C]}
                          : {alu_o[7:0] == 8'h00, 1'b0, 1'b0, alu_fout[FLAG_C]};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      opReg <= '0;
      memData <= '0;
      wrData <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && start) opReg <= cb_opcode;
      if (state == MEM_RD && mem.ack) memData <= mem.rdata;
      if (state == EXEC) wrData <= alu_o[7:0];
    end
  end
  always_comb begin
    nextState = state;
    busy = 1'b0;
    done = 1'b0;
    flags_out = '0;
    flags_we = 1'b0;
    rf_rsel = '0;
    rf_we = 1'b0;
    rf_wsel = '0;
    rf_wdata = '0;
    mem.req = 1'b0;
    mem.we = 1'b0;
    mem.addr = '0;
    mem.wdata = '0;
    alu_op = '0;
    alu_x = '0;
    alu_y = '0;
    alu_fin = '0;
    case (state)
      IDLE: if (start) nextState = isMemOperand(cb_opcode) ? MEM_RD : EXEC;
      MEM_RD: begin
        busy = 1'b1;
        mem.req = 1'b1;
        mem.addr = hl;
        if (mem.ack) nextState = EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        rf_rsel = isMem ? 3'd0 : opReg[2:0];
        alu_op = aluOp;
        alu_x = {8'h00, operand};
        alu_fin = flags_in;
        rf_we = writesReg;
        rf_wsel = writesReg ? opReg[2:0] : 3'd0;
        rf_wdata = writesReg ? alu_o[7:0] : 8'h00;
        flags_we = writesFlags;
        flags_out = writesFlags ? newFlags : 4'h0;
        nextState = isMem && !isBit ? MEM_WR : DONE;
      end
      MEM_WR: begin
        busy = 1'b1;
        mem.req = 1'b1;
        mem.we = 1'b1;
        mem.addr = hl;
        mem.wdata = wrData;
        if (mem.ack) nextState = DONE;
      end
      DONE: begin
        done = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cb_executor.sv
// tb_cb_executor: randomized and directed checks of cb_executor against a behavioural CB model
module tb_cb_executor;
  import cb_executor_pkg::*;
  logic clk = 1'b0;
  logic reset, start, busy, done, flags_we, rf_we;
  logic [7:0] cb_opcode, rf_rdata, rf_wdata, alu_op;
  logic [15:0] hl, alu_x, alu_y, alu_o;
  logic [3:0] flags_in, flags_out, alu_fin, alu_fout;
  logic [2:0] rf_rsel, rf_wsel;
  cb_executor_if mem();
  always #5 clk = ~clk;
  cb_executor dut (
    .clk(clk), .reset(reset), .start(start), .cb_opcode(cb_opcode), .busy(busy), .done(done),
    .hl(hl), .flags_in(flags_in), .flags_out(flags_out), .flags_we(flags_we),
    .rf_rsel(rf_rsel), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata),
    .mem(mem), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_fin(alu_fin),
    .alu_o(alu_o), .alu_fout(alu_fout)
  );
  int vectors = 0, miscompares = 0;
  logic [7:0] regs [8];
  logic [7:0] memByte;
  int rdWait = 0, wrWait = 0, waitCnt = 0;
  int rdCount, wrCount, rfWrCount, flagWrCount, doneCount, aluBad;
  logic [15:0] rdAddr, wrAddr;
  logic [7:0] wrByte, lastWdata;
  logic [2:0] lastWsel;
  logic [3:0] lastFlags;
  // Reference CB semantics: returns {carry out, result byte}.
  function automatic logic [8:0] refCalc(input logic [7:0] op, input logic [7:0] v, input logic c);
    logic [7:0] m;
    m = 8'd1 << op[5:3];
    case (op[7:6])
      2'b00:
        case (op[5:3])
          3'd0: return {v[7], v[6:0], v[7]};
          3'd1: return {v[0], v[0], v[7:1]};
          3'd2: return {v[7], v[6:0], c};
          3'd3: return {v[0], c, v[7:1]};
          3'd4: return {v[7], v[6:0], 1'b0};
          3'd5: return {v[0], v[7], v[7:1]};
          3'd6: return {1'b0, v[3:0], v[7:4]};
          default: return {v[0], 1'b0, v[7:1]};
        endcase
      2'b01: return {1'b0, v};
      2'b10: return {1'b0, v & ~m};
      default: return {1'b0, v | m};
    endcase
  endfunction
  // External ALU stand-in: junk upper byte, inverted Z for rotates and inverted C for BIT.
  logic [7:0] aluCbOp;
  logic [8:0] aluCalc;
  always_comb begin
    aluCbOp = {alu_op[7:4] == ALU_RLC[7:4] ? 2'b00 : alu_op[7:4] == ALU_BIT[7:4] ? 2'b01 :
               alu_op[7:4] == ALU_RES[7:4] ? 2'b10 : 2'b11, alu_op[2:0], 3'b000};
    aluCalc = refCalc(aluCbOp, alu_x[7:0], alu_fin[0]);
    alu_o = {8'hA5, aluCalc[7:0]};
    alu_fout = aluCbOp[7:6] == 2'b00 ? {aluCalc[7:0] != 8'h00, 2'b11, aluCalc[8]}
                                     : {~alu_x[alu_op[2:0]], 2'b01, ~alu_fin[0]};
    rf_rdata = regs[rf_rsel];
  end
  initial begin
    mem.ack = 1'b0;
    mem.rdata = 8'h00;
  end
  always @(negedge clk) begin
    if (mem.req) begin
      mem.ack = waitCnt >= (mem.we ? wrWait : rdWait);
      mem.rdata = memByte;
      waitCnt = mem.ack ? 0 : waitCnt + 1;
      if (mem.ack && mem.we) begin
        wrCount++;
        wrAddr = mem.addr;
        wrByte = mem.wdata;
      end else if (mem.ack) begin
        rdCount++;
        rdAddr = mem.addr;
      end
    end else begin
      mem.ack = 1'b0;
      waitCnt = 0;
    end
    if (rf_we) begin
      rfWrCount++;
      lastWsel = rf_wsel;
      lastWdata = rf_wdata;
    end
    if (flags_we) begin
      flagWrCount++;
      lastFlags = flags_out;
    end
    if (done) doneCount++;
    if (alu_op != 8'h00 && (alu_fin !== flags_in || alu_y !== 16'h0 || alu_x[15:8] !== 8'h00)) aluBad++;
  end
  task automatic clearStats();
    rdCount = 0; wrCount = 0; rfWrCount = 0; flagWrCount = 0; doneCount = 0; aluBad = 0;
    lastWdata = 'x; lastWsel = 'x; lastFlags = 'x; wrByte = 'x; wrAddr = 'x; rdAddr = 'x;
  endtask
  task automatic runOp(input logic [7:0] op, input logic [7:0] v, input logic [3:0] fin,
                       input logic [15:0] a, input int rw, input int ww, input bit poke);
    logic [8:0] calc;
    logic [3:0] expFlags;
    bit isMem, expRfWe, expFlagWe, expWr;
    int expLat, lat, busyBad, idleBad;
    calc = refCalc(op, v, fin[0]);
    isMem = op[2:0] == 3'd6;
    expRfWe = op[7:6] != 2'b01 && !isMem;
    expFlagWe = !op[7];
    expWr = isMem && op[7:6] != 2'b01;
    expFlags = op[7:6] == 2'b00 ? {calc[7:0] == 8'h00, 2'b00, calc[8]} : {~v[op[5:3]], 2'b01, fin[0]};
    expLat = 2 + (isMem ? 1 + rw + (op[7:6] == 2'b01 ? 0 : 1 + ww) : 0);
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    if (!isMem) regs[op[2:0]] = v;
    memByte = isMem ? v : 8'($urandom);
    hl = a;
    flags_in = fin;
    rdWait = rw;
    wrWait = ww;
    lat = 0; busyBad = 0; idleBad = 0;
    @(negedge clk);
    clearStats();
    cb_opcode = op;
    start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = poke;
      if (poke) cb_opcode = ~op;
      if (done) begin
        lat = i;
        if (busy) busyBad++;
        break;
      end
      if (!busy) busyBad++;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy || done) idleBad++;
    end
    vectors++;
    if (lat === 0) begin
      miscompares++;
      $display("FAIL timeout op=%02h: no done within 60 cycles", op);
    end else if (lat !== expLat) begin
      miscompares++;
      $display("FAIL latency op=%02h: got %0d cycles, want %0d", op, lat, expLat);
    end
    vectors++;
    if (doneCount !== 1 || idleBad !== 0) begin
      miscompares++;
      $display("FAIL done_count op=%02h: got %0d dones (%0d idle busy), want 1", op, doneCount, idleBad);
    end
    vectors++;
    if (busyBad !== 0) begin
      miscompares++;
      $display("FAIL busy op=%02h: %0d bad busy cycles, want 0", op, busyBad);
    end
    vectors++;
    if (rfWrCount !== int'(expRfWe)) begin
      miscompares++;
      $display("FAIL rf_we_count op=%02h: got %0d, want %0d", op, rfWrCount, expRfWe);
    end
    if (expRfWe) begin
      vectors++;
      if ({lastWsel, lastWdata} !== {op[2:0], calc[7:0]}) begin
        miscompares++;
        $display("FAIL rf_write op=%02h: got sel %0d data %02h, want sel %0d data %02h", op, lastWsel, lastWdata, op[2:0], calc[7:0]);
      end
    end
    vectors++;
    if (flagWrCount !== int'(expFlagWe)) begin
      miscompares++;
      $display("FAIL flags_we_count op=%02h: got %0d, want %0d", op, flagWrCount, expFlagWe);
    end
    if (expFlagWe) begin
      vectors++;
      if (lastFlags !== expFlags) begin
        miscompares++;
        $display("FAIL flags op=%02h v=%02h: got %b, want %b", op, v, lastFlags, expFlags);
      end
    end
    vectors++;
    if (rdCount !== int'(isMem) || wrCount !== int'(expWr)) begin
      miscompares++;
      $display("FAIL mem_count op=%02h: got %0d rd %0d wr, want %0d rd %0d wr", op, rdCount, wrCount, isMem, expWr);
    end
    if (isMem) begin
      vectors++;
      if (rdAddr !== a) begin
        miscompares++;
        $display("FAIL mem_rd_addr op=%02h: got %04h, want %04h", op, rdAddr, a);
      end
    end
    if (expWr) begin
      vectors++;
      if ({wrAddr, wrByte} !== {a, calc[7:0]}) begin
        miscompares++;
        $display("FAIL mem_write op=%02h: got %04h<=%02h, want %04h<=%02h", op, wrAddr, wrByte, a, calc[7:0]);
      end
    end
    vectors++;
    if (aluBad !== 0) begin
      miscompares++;
      $display("FAIL alu_drive op=%02h: %0d bad cycles on alu_x/alu_y/alu_fin, want 0", op, aluBad);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    cb_opcode = 8'h00;
    hl = 16'h0000;
    flags_in = 4'h0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, flags_we, rf_we, mem.req, mem.we, flags_out, rf_rsel, rf_wsel, rf_wdata,
         mem.addr, mem.wdata, alu_op, alu_x, alu_y, alu_fin} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b req=%b alu_op=%02h addr=%04h, want all zero", busy, done, mem.req, alu_op, mem.addr);
    end
    reset = 1'b0;
  endtask
  task automatic test_directed();
    runOp(8'h00, 8'h85, 4'b0000, 16'h1234, 0, 0, 1'b0);
    vectors++;
    if ({lastWsel, lastWdata, lastFlags} !== {3'd0, 8'h0B, 4'b0001}) begin
      miscompares++;
      $display("FAIL rlc_b: got sel %0d data %02h flags %b, want 0 0B 0001", lastWsel, lastWdata, lastFlags);
    end
    runOp(8'h17, 8'h80, 4'b0000, 16'h1234, 0, 0, 1'b0);
    vectors++;
    if ({lastWsel, lastWdata, lastFlags} !== {3'd7, 8'h00, 4'b1001}) begin
      miscompares++;
      $display("FAIL rl_a: got sel %0d data %02h flags %b, want 7 00 1001", lastWsel, lastWdata, lastFlags);
    end
    runOp(8'h7C, 8'h7F, 4'b0001, 16'h1234, 0, 0, 1'b0);
    vectors++;
    if (lastFlags !== 4'b1011) begin
      miscompares++;
      $display("FAIL bit7_h: got flags %b, want 1011", lastFlags);
    end
    runOp(8'hDE, 8'h00, 4'b0101, 16'hC000, 3, 3, 1'b0);
    vectors++;
    if ({wrAddr, wrByte, flagWrCount} !== {16'hC000, 8'h08, 32'd0}) begin
      miscompares++;
      $display("FAIL set3_hl: got %04h<=%02h flag writes %0d, want C000<=08 0", wrAddr, wrByte, flagWrCount);
    end
    runOp(8'h36, 8'h00, 4'b0111, 16'h8000, 0, 0, 1'b0);
    vectors++;
    if ({wrByte, lastFlags} !== {8'h00, 4'b1000}) begin
      miscompares++;
      $display("FAIL swap_hl: got data %02h flags %b, want 00 1000", wrByte, lastFlags);
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 80; n++)
      runOp(8'($urandom), 8'($urandom), 4'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
  endtask
  task automatic test_back_to_back();
    runOp(8'h46, 8'h01, 4'b0000, 16'hFF80, 1, 0, 1'b1);
    runOp(8'h11, 8'h55, 4'b1111, 16'h0000, 0, 0, 1'b1);
    for (int n = 0; n < 10; n++)
      runOp(8'($urandom), 8'($urandom), 4'($urandom), 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
  endtask
  task automatic test_reset_mid();
    memByte = 8'h3C;
    hl = 16'hC123;
    rdWait = 6;
    @(negedge clk);
    clearStats();
    cb_opcode = 8'hC6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem.req !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_setup: got mem_req %b in read phase, want 1", mem.req);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem.req, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_reset_abort: got mem_req %b busy %b, want 0 0", mem.req, busy);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (rdCount + wrCount + rfWrCount + flagWrCount + doneCount !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_writes: got rd %0d wr %0d rf %0d flags %0d done %0d, want none", rdCount, wrCount, rfWrCount, flagWrCount, doneCount);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    runOp(8'hCB, 8'hF0, 4'b0000, 16'h0042, 0, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
